pipeline_hazard_controller: RTL and testbench

Issue controller for the three-stage post-decode pipeline: register one, register two and register three. Each cycle it decides whether the instruction in decode may issue, based on a scoreboard of in-flight general-register writes and stack-pointer operations. It drives the decode hold, bubble-insert and fetch/decode flush controls, and it sequences branch (PC_load) resolution, which completes only when the branch leaves the last stage.

---
 rtl/pipe_ctrl_pkg.sv | 34 +++
 rtl/hazard_scoreboard.sv | 100 ++++++++++
 rtl/pipeline_hazard_controller.sv | 134 +++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared definitions for the post-decode issue controller:
//   - FSM state encoding (RUN/HAZ/BRWAIT/FLUSH), also visible on STATE_OUT
//   - scoreboard entry bit layout and a width helper
//   - default pipeline depth, flush length and register address width
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    HAZ    = 2'b01,
    BRWAIT = 2'b10,
    FLUSH  = 2'b11
  } state_e;

  localparam int DEPTH_DEF        = 3;
  localparam int FLUSH_CYCLES_DEF = 2;
  localparam int REG_AW_DEF       = 3;

  // The flush counter must hold values up to 15.
  localparam int CNT_W = 4;

  // Scoreboard entry layout, LSB first:
  //   [0] pcload, [1] spr, [2] write, [3] valid, [4 +: REG_AW] writeAd
  localparam int SB_PCLOAD  = 0;
  localparam int SB_SPR     = 1;
  localparam int SB_WRITE   = 2;
  localparam int SB_VALID   = 3;
  localparam int SB_WAD_LSB = 4;

  function automatic int sbEntryWidth(input int aw);
    return aw + SB_WAD_LSB;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// Shift register mirroring the post-decode pipeline registers. Entry k
// (index k-1) describes the instruction held in pipeline register k.
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   load_i                  decode instruction is issuing this cycle
//   writeAd_i, write_i      destination register and its write enable
//   spr_i, pcload_i         instruction modifies SP / is a branch
//   readA_i/useA_i,
//   readB_i/useB_i          decode source registers and their use flags
//   sprAccess_i             decode instruction reads or modifies SP
//   data_haz_o              a source matches an in-flight write
//   sp_haz_o                SP access while an SP modifier is in flight
//   br_done_o               a branch occupies the last tracked stage
module hazard_scoreboard
  import pipe_ctrl_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [REG_AW-1:0] writeAd_i,
  input  logic              write_i,
  input  logic              spr_i,
  input  logic              pcload_i,
  input  logic [REG_AW-1:0] readA_i,
  input  logic              useA_i,
  input  logic [REG_AW-1:0] readB_i,
  input  logic              useB_i,
  input  logic              sprAccess_i,
  output logic              data_haz_o,
  output logic              sp_haz_o,
  output logic              br_done_o
);

  localparam int EW = sbEntryWidth(REG_AW);

  logic [EW-1:0] entry_q [DEPTH];
  logic [EW-1:0] entry_d [DEPTH];
  logic [EW-1:0] newEntry;
  logic          dataHaz;
  logic          sprInFlight;

  // A non-issuing cycle loads an all-zero (invalid) entry, so a held
  // instruction never appears twice in the pipeline.
  always_comb begin
    newEntry                          = '0;
    newEntry[SB_VALID]                = load_i;
    newEntry[SB_WRITE]                = load_i & write_i;
    newEntry[SB_SPR]                  = load_i & spr_i;
    newEntry[SB_PCLOAD]               = load_i & pcload_i;
    newEntry[SB_WAD_LSB +: REG_AW]    = load_i ? writeAd_i : '0;

    entry_d[0] = newEntry;
    for (int k = 1; k < DEPTH; k++) begin
      entry_d[k] = entry_q[k-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < DEPTH; k++) begin
        entry_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        entry_q[k] <= entry_d[k];
      end
    end
  end

  // Every stage is compared, including the last: a write there only
  // becomes architecturally visible on the following cycle.
  always_comb begin
    dataHaz     = 1'b0;
    sprInFlight = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (entry_q[k][SB_VALID]) begin
        if (entry_q[k][SB_WRITE]) begin
          if (useA_i && (entry_q[k][SB_WAD_LSB +: REG_AW] == readA_i)) begin
            dataHaz = 1'b1;
          end
          if (useB_i && (entry_q[k][SB_WAD_LSB +: REG_AW] == readB_i)) begin
            dataHaz = 1'b1;
          end
        end
        if (entry_q[k][SB_SPR]) begin
          sprInFlight = 1'b1;
        end
      end
    end
  end

  assign data_haz_o = dataHaz;
  assign sp_haz_o   = sprInFlight & sprAccess_i;
  assign br_done_o  = entry_q[DEPTH-1][SB_VALID] & entry_q[DEPTH-1][SB_PCLOAD];

endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
// Decides each cycle whether the decode instruction may issue into
// pipeline register one, and sequences branch resolution plus the
// fetch/decode flush that follows.
// Ports:
//   CLK, RST_N                   clock, asynchronous active-low reset
//   ISSUE_VALID                  decode holds a valid instruction
//   readA_IN/useA_IN,
//   readB_IN/useB_IN             source registers and use flags
//   writeAd_IN, write_IN         destination register and write enable
//   PC_load_IN                   instruction is a branch/jump
//   SPR_op_IN, SPR_use_IN        instruction modifies / reads SP
//   ISSUE_OUT                    instruction accepted this cycle
//   STALL_OUT                    hold PC and decode register
//   BUBBLE_OUT                   zero register-one control bits
//   FLUSH_OUT                    invalidate fetch and decode
//   STATE_OUT                    current FSM state (debug)
module pipeline_hazard_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int DEPTH        = DEPTH_DEF,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int REG_AW       = REG_AW_DEF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              ISSUE_VALID,
  input  logic [REG_AW-1:0] readA_IN,
  input  logic [REG_AW-1:0] readB_IN,
  input  logic              useA_IN,
  input  logic              useB_IN,
  input  logic [REG_AW-1:0] writeAd_IN,
  input  logic              write_IN,
  input  logic              PC_load_IN,
  input  logic              SPR_op_IN,
  input  logic              SPR_use_IN,
  output logic              ISSUE_OUT,
  output logic              STALL_OUT,
  output logic              BUBBLE_OUT,
  output logic              FLUSH_OUT,
  output logic [1:0]        STATE_OUT
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] flushCnt_q, flushCnt_d;
  logic             dataHaz, spHaz, brDone, hazard;
  logic             issue, stall, flush;

  hazard_scoreboard #(
    .DEPTH  (DEPTH),
    .REG_AW (REG_AW)
  ) u_scoreboard (
    .clk_i       (CLK),
    .rst_ni      (RST_N),
    .load_i      (ISSUE_OUT),
    .writeAd_i   (writeAd_IN),
    .write_i     (write_IN),
    .spr_i       (SPR_op_IN),
    .pcload_i    (PC_load_IN),
    .readA_i     (readA_IN),
    .useA_i      (useA_IN),
    .readB_i     (readB_IN),
    .useB_i      (useB_IN),
    .sprAccess_i (SPR_use_IN | SPR_op_IN),
    .data_haz_o  (dataHaz),
    .sp_haz_o    (spHaz),
    .br_done_o   (brDone)
  );

  assign hazard = dataHaz | spHaz;

  // RUN and HAZ share the issue rule; HAZ only records that decode is
  // being held. A branch that also has a hazard waits in HAZ and moves
  // to BRWAIT on the cycle it finally issues.
  always_comb begin
    state_d    = state_q;
    flushCnt_d = flushCnt_q;
    issue      = 1'b0;
    stall      = 1'b0;
    flush      = 1'b0;
    case (state_q)
      RUN, HAZ: begin
        issue = ISSUE_VALID & ~hazard;
        stall = ISSUE_VALID & hazard;
        if (issue && PC_load_IN) begin
          state_d = BRWAIT;
        end else if (ISSUE_VALID && hazard) begin
          state_d = HAZ;
        end else begin
          state_d = RUN;
        end
      end
      BRWAIT: begin
        stall = 1'b1;
        if (brDone) begin
          state_d    = FLUSH;
          flushCnt_d = CNT_W'(FLUSH_CYCLES);
        end
      end
      FLUSH: begin
        flush = 1'b1;
        // The <= guard keeps a zero count from wrapping and locking up.
        if (flushCnt_q <= CNT_W'(1)) begin
          state_d    = RUN;
          flushCnt_d = '0;
        end else begin
          flushCnt_d = flushCnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= RUN;
      flushCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      flushCnt_q <= flushCnt_d;
    end
  end

  // Outputs are gated by RST_N so a valid decode slot is ignored while
  // reset is held.
  assign ISSUE_OUT  = RST_N & issue;
  assign STALL_OUT  = RST_N & stall;
  assign FLUSH_OUT  = RST_N & flush;
  assign BUBBLE_OUT = ~ISSUE_OUT;
  assign STATE_OUT  = state_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller
// Table-driven check of the issue controller with default parameters,
// followed by hand-written reset-abort sequences.
module tb_pipeline_hazard_controller;

  localparam int DEPTH        = 3;
  localparam int FLUSH_CYCLES = 2;
  localparam int REG_AW       = 3;

  localparam logic [1:0] S_RUN    = 2'b00;
  localparam logic [1:0] S_HAZ    = 2'b01;
  localparam logic [1:0] S_BRWAIT = 2'b10;
  localparam logic [1:0] S_FLUSH  = 2'b11;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic              ISSUE_VALID;
  logic [REG_AW-1:0] readA_IN, readB_IN, writeAd_IN;
  logic              useA_IN, useB_IN, write_IN, PC_load_IN, SPR_op_IN, SPR_use_IN;
  logic              ISSUE_OUT, STALL_OUT, BUBBLE_OUT, FLUSH_OUT;
  logic [1:0]        STATE_OUT;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string             name;
    logic              iv;
    logic [REG_AW-1:0] rA;
    logic              uA;
    logic [REG_AW-1:0] rB;
    logic              uB;
    logic [REG_AW-1:0] wAd;
    logic              wr;
    logic              pc;
    logic              spOp;
    logic              spUse;
    logic              eIssue;
    logic              eStall;
    logic              eFlush;
    logic [1:0]        eState;
  } vec_t;

  vec_t tbl[$];

  pipeline_hazard_controller #(
    .DEPTH        (DEPTH),
    .FLUSH_CYCLES (FLUSH_CYCLES),
    .REG_AW       (REG_AW)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .ISSUE_VALID (ISSUE_VALID),
    .readA_IN    (readA_IN),
    .readB_IN    (readB_IN),
    .useA_IN     (useA_IN),
    .useB_IN     (useB_IN),
    .writeAd_IN  (writeAd_IN),
    .write_IN    (write_IN),
    .PC_load_IN  (PC_load_IN),
    .SPR_op_IN   (SPR_op_IN),
    .SPR_use_IN  (SPR_use_IN),
    .ISSUE_OUT   (ISSUE_OUT),
    .STALL_OUT   (STALL_OUT),
    .BUBBLE_OUT  (BUBBLE_OUT),
    .FLUSH_OUT   (FLUSH_OUT),
    .STATE_OUT   (STATE_OUT)
  );

  always #5 CLK = ~CLK;

  function automatic vec_t mk(input string name, input logic iv,
                              input int rA, input logic uA, input int rB, input logic uB,
                              input int wAd, input logic wr, input logic pc,
                              input logic spOp, input logic spUse,
                              input logic eI, input logic eS, input logic eF,
                              input logic [1:0] eSt);
    vec_t v;
    v.name = name; v.iv = iv;
    v.rA = REG_AW'(rA); v.uA = uA; v.rB = REG_AW'(rB); v.uB = uB;
    v.wAd = REG_AW'(wAd); v.wr = wr; v.pc = pc; v.spOp = spOp; v.spUse = spUse;
    v.eIssue = eI; v.eStall = eS; v.eFlush = eF; v.eState = eSt;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    ISSUE_VALID = v.iv;
    readA_IN    = v.rA;
    useA_IN     = v.uA;
    readB_IN    = v.rB;
    useB_IN     = v.uB;
    writeAd_IN  = v.wAd;
    write_IN    = v.wr;
    PC_load_IN  = v.pc;
    SPR_op_IN   = v.spOp;
    SPR_use_IN  = v.spUse;
  endtask

  task automatic checkBit(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string name, input logic eI, input logic eS,
                             input logic eF, input logic [1:0] eSt);
    checkBit({name, ".issue"},  {1'b0, ISSUE_OUT},  {1'b0, eI});
    checkBit({name, ".stall"},  {1'b0, STALL_OUT},  {1'b0, eS});
    checkBit({name, ".bubble"}, {1'b0, BUBBLE_OUT}, {1'b0, ~eI});
    checkBit({name, ".flush"},  {1'b0, FLUSH_OUT},  {1'b0, eF});
    checkBit({name, ".state"},  STATE_OUT,          eSt);
  endtask

  task automatic runVec(input vec_t v);
    @(posedge CLK);
    #1 applyStimulus(v);
    @(negedge CLK);
    checkOutput(v.name, v.eIssue, v.eStall, v.eFlush, v.eState);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //             name          iv rA uA rB uB wAd wr pc so su  I  S  F  state
    tbl.push_back(mk("idle0",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, S_RUN));
    tbl.push_back(mk("idle1",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, S_RUN));
    tbl.push_back(mk("wrR3",      1, 0, 0, 0, 0, 3, 1, 0, 0, 0,  1, 0, 0, S_RUN));
    tbl.push_back(mk("rdR3.c1",   1, 3, 1, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, S_RUN));
    tbl.push_back(mk("rdR3.c2",   1, 3, 1, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, S_HAZ));
    tbl.push_back(mk("rdR3.c3",   1, 3, 1, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, S_HAZ));
    tbl.push_back(mk("rdR3.c4",   1, 3, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, S_HAZ));
    tbl.push_back(mk("wrR3b",     1, 0, 0, 0, 0, 3, 1, 0, 0, 0,  1, 0, 0, S_RUN));
    tbl.push_back(mk("rdBR4",     1, 3, 0, 4, 1, 0, 0, 0, 0, 0,  1, 0, 0, S_RUN));
    tbl.push_back(mk("idle2",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, S_RUN));
    tbl.push_back(mk("idle3",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, S_RUN));
    tbl.push_back(mk("sprOp",     1, 0, 0, 0, 0, 0, 0, 0, 1, 0,  1, 0, 0, S_RUN));
    tbl.push_back(mk("sprUse.c1", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 0, S_RUN));
    tbl.push_back(mk("sprUse.c2", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 0, S_HAZ));
    tbl.push_back(mk("sprUse.c3", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 0, S_HAZ));
    tbl.push_back(mk("sprUse.c4", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, S_HAZ));
    tbl.push_back(mk("sprOp2",    1, 0, 0, 0, 0, 0, 0, 0, 1, 0,  1, 0, 0, S_RUN));
    tbl.push_back(mk("rdR0",      1, 0, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, S_RUN));
    tbl.push_back(mk("branch",    1, 0, 0, 0, 0, 0, 0, 1, 0, 0,  1, 0, 0, S_RUN));
    tbl.push_back(mk("brwait1",   1, 1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, S_BRWAIT));
    tbl.push_back(mk("brwait2",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, S_BRWAIT));
    tbl.push_back(mk("brwait3",   1, 1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, S_BRWAIT));
    tbl.push_back(mk("flush1",    1, 1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, S_FLUSH));
    tbl.push_back(mk("flush2",    1, 1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, S_FLUSH));
    tbl.push_back(mk("postFlush", 1, 2, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, S_RUN));
    tbl.push_back(mk("wrR5",      1, 0, 0, 0, 0, 5, 1, 0, 0, 0,  1, 0, 0, S_RUN));
    tbl.push_back(mk("hazBr.c1",  1, 5, 1, 0, 0, 0, 0, 1, 0, 0,  0, 1, 0, S_RUN));
    tbl.push_back(mk("hazBr.c2",  1, 5, 1, 0, 0, 0, 0, 1, 0, 0,  0, 1, 0, S_HAZ));
    tbl.push_back(mk("hazBr.c3",  1, 5, 1, 0, 0, 0, 0, 1, 0, 0,  0, 1, 0, S_HAZ));
    tbl.push_back(mk("hazBr.c4",  1, 5, 1, 0, 0, 0, 0, 1, 0, 0,  1, 0, 0, S_HAZ));
    tbl.push_back(mk("hazBr.bw1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, S_BRWAIT));
    tbl.push_back(mk("hazBr.bw2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, S_BRWAIT));
    tbl.push_back(mk("hazBr.bw3", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, S_BRWAIT));
    tbl.push_back(mk("hazBr.fl1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, S_FLUSH));
    tbl.push_back(mk("hazBr.fl2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, S_FLUSH));
    tbl.push_back(mk("b2b.wrR1",  1, 0, 0, 0, 0, 1, 1, 0, 0, 0,  1, 0, 0, S_RUN));
    tbl.push_back(mk("b2b.wrR2",  1, 7, 1, 0, 0, 2, 1, 0, 0, 0,  1, 0, 0, S_RUN));
    tbl.push_back(mk("b2b.rdR6",  1, 0, 0, 6, 1, 0, 0, 0, 0, 0,  1, 0, 0, S_RUN));
    tbl.push_back(mk("lastStage", 1, 1, 1, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, S_RUN));
    tbl.push_back(mk("lastClear", 1, 1, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, S_HAZ));
    tbl.push_back(mk("idleEnd",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, S_RUN));

    // Reset with a valid decode slot: it must be ignored.
    RST_N = 1'b0;
    applyStimulus(mk("rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, S_RUN));
    #2 checkOutput("reset", 1'b0, 1'b0, 1'b0, S_RUN);
    repeat (2) @(posedge CLK);
    #1;
    ISSUE_VALID = 1'b0;
    RST_N       = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      runVec(tbl[i]);
    end

    // Reset mid-BRWAIT while a branch-and-link write of r7 is in flight.
    runVec(mk("rstA.branch", 1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 1, 0, 0, S_RUN));
    runVec(mk("rstA.bw1",    1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, S_BRWAIT));
    runVec(mk("rstA.bw2",    1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, S_BRWAIT));
    #1 RST_N = 1'b0;
    #1 checkOutput("rstA.inReset", 1'b0, 1'b0, 1'b0, S_RUN);
    #1 RST_N = 1'b1;
    runVec(mk("rstA.readR7", 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, S_RUN));

    // Reset on the first FLUSH cycle of a branch sequence.
    runVec(mk("rstB.branch", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, S_RUN));
    runVec(mk("rstB.bw1",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, S_BRWAIT));
    runVec(mk("rstB.bw2",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, S_BRWAIT));
    runVec(mk("rstB.bw3",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, S_BRWAIT));
    runVec(mk("rstB.fl1",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, S_FLUSH));
    #1 RST_N = 1'b0;
    #1 checkOutput("rstB.inReset", 1'b0, 1'b0, 1'b0, S_RUN);
    #1 RST_N = 1'b1;
    runVec(mk("rstB.issue",  1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, S_RUN));
    runVec(mk("rstB.noFlush",0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, S_RUN));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
